// File: rtl/nn_mlp_seq_if.sv
// Handshake, weight-load and status bundle for nn_mlp_seq.
// The master drives inputs and weight writes; the slave is the network core.
interface nn_mlp_seq_if #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned N_HID = 13,
    parameter int unsigned W     = 17
);
    localparam int unsigned AW = $clog2(N_HID * (N_IN + 1) + N_HID + 1);

    logic              in_valid;
    logic              in_ready;
    logic [N_IN*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_sat;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [W-1:0]      w_data;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready, w_we, w_addr, w_data,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, w_we, w_addr, w_data,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/nn_mlp_seq.sv
// Time-multiplexed N_IN -> N_HID -> 1 perceptron sharing a single multiply-accumulate unit.
// Weights live in a register file with combinational read; one product per cycle.
module nn_mlp_seq #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned N_HID = 13,
    parameter int unsigned W     = 17,
    parameter int unsigned F     = 12,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned ACT   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    nn_mlp_seq_if.slave  io_bus
);
    localparam int unsigned B  = N_HID * (N_IN + 1);
    localparam int unsigned NW = B + N_HID + 1;
    localparam int unsigned CW = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
    localparam int unsigned HW = $clog2(N_HID + 1);

    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W - W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [W-1:0]     ONE     = W'(1 << F);
    localparam logic signed [W-1:0]     NEG_ONE = -ONE;

    typedef enum logic [2:0] {StIdle, StHmac, StHact, StOmac, StOact, StHold} state_e;

    state_e                   r_state, w_state_d;
    logic [CW-1:0]            r_cnt;
    logic [HW-1:0]            r_h;
    logic signed [W-1:0]      r_x   [N_IN];
    logic signed [W-1:0]      r_hid [N_HID];
    logic signed [W-1:0]      r_w   [NW];
    logic signed [ACC_W-1:0]  r_acc;
    logic [W-1:0]             r_out;
    logic                     r_sat;

    int unsigned              w_raddr;
    logic signed [W-1:0]      w_opd, w_wgt, w_y, w_act;
    logic signed [2*W-1:0]    w_opd_x, w_wgt_x, w_prod;
    logic signed [ACC_W-1:0]  w_term, w_acc_d, w_shr;
    logic                     w_bias, w_hi, w_lo, w_accept;

    assign w_accept = io_bus.in_valid && (r_state == StIdle);

    // Operand fetch: weight by address, data from latched inputs or hidden layer.
    always_comb begin
        w_opd   = '0;
        w_wgt   = '0;
        w_raddr = (r_state == StOmac) ? B + 32'(r_cnt) : 32'(r_h) * (N_IN + 1) + 32'(r_cnt);
        for (int unsigned i = 0; i < NW; i++) begin
            if (w_raddr == i) w_wgt = r_w[i];
        end
        if (r_state == StOmac) begin
            for (int unsigned i = 0; i < N_HID; i++) begin
                if (r_cnt == CW'(i)) w_opd = r_hid[i];
            end
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (r_cnt == CW'(i)) w_opd = r_x[i];
            end
        end
    end

    // The last slot of every neuron adds the bias, scaled into the product's Q format.
    assign w_bias  = (r_state == StOmac) ? (r_cnt == CW'(N_HID)) : (r_cnt == CW'(N_IN));
    assign w_opd_x = {{W{w_opd[W-1]}}, w_opd};
    assign w_wgt_x = {{W{w_wgt[W-1]}}, w_wgt};
    assign w_prod  = w_opd_x * w_wgt_x;
    assign w_term  = w_bias ? {{(ACC_W - W - F){w_wgt[W-1]}}, w_wgt, {F{1'b0}}}
                            : {{(ACC_W - 2 * W){w_prod[2*W-1]}}, w_prod};
    assign w_acc_d = ((r_cnt == '0) ? '0 : r_acc) + w_term;

    // Rescale with floor shift, then clamp to the W-bit range.
    assign w_shr = r_acc >>> F;
    assign w_hi  = w_shr > SMAX;
    assign w_lo  = w_shr < SMIN;
    assign w_y   = w_hi ? SMAX[W-1:0] : (w_lo ? SMIN[W-1:0] : w_shr[W-1:0]);

    // Hidden activation: hard-tanh clip or ReLU, selected at elaboration.
    always_comb begin
        w_act = w_y;
        if (ACT == 0) begin
            if (w_y > ONE)          w_act = ONE;
            else if (w_y < NEG_ONE) w_act = NEG_ONE;
        end else if (w_y[W-1]) begin
            w_act = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    // Next-state sequencing through hidden neurons, then the output neuron.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (io_bus.in_valid) w_state_d = StHmac;
            StHmac:  if (r_cnt == CW'(N_IN)) w_state_d = StHact;
            StHact:  w_state_d = (r_h == HW'(N_HID - 1)) ? StOmac : StHmac;
            StOmac:  if (r_cnt == CW'(N_HID)) w_state_d = StOact;
            StOact:  w_state_d = StHold;
            StHold:  if (io_bus.out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Weight register file; writes only land while idle and inside the map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NW; i++) r_w[i] <= '0;
        end else if (io_bus.w_we && (r_state == StIdle)) begin
            for (int unsigned i = 0; i < NW; i++) begin
                if (32'(io_bus.w_addr) == i) r_w[i] <= io_bus.w_data;
            end
        end
    end

    // Datapath: input latch, accumulator, slot counters, hidden layer and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_h   <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_sat <= 1'b0;
            for (int unsigned i = 0; i < N_IN; i++)  r_x[i]   <= '0;
            for (int unsigned i = 0; i < N_HID; i++) r_hid[i] <= '0;
        end else begin
            case (r_state)
                StIdle: if (w_accept) begin
                    r_cnt <= '0;
                    r_h   <= '0;
                    r_sat <= 1'b0;
                    for (int unsigned i = 0; i < N_IN; i++) begin
                        r_x[i] <= io_bus.in_data[(N_IN - 1 - i) * W +: W];
                    end
                end
                StHmac: begin
                    r_acc <= w_acc_d;
                    r_cnt <= (r_cnt == CW'(N_IN)) ? '0 : r_cnt + 1'b1;
                end
                StHact: begin
                    for (int unsigned i = 0; i < N_HID; i++) begin
                        if (r_h == HW'(i)) r_hid[i] <= w_act;
                    end
                    r_sat <= r_sat | w_hi | w_lo;
                    r_h   <= (r_h == HW'(N_HID - 1)) ? '0 : r_h + 1'b1;
                end
                StOmac: begin
                    r_acc <= w_acc_d;
                    r_cnt <= (r_cnt == CW'(N_HID)) ? '0 : r_cnt + 1'b1;
                end
                StOact: begin
                    r_out <= w_y;
                    r_sat <= r_sat | w_hi | w_lo;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == StIdle);
    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.out_valid = (r_state == StHold);
    assign io_bus.out_data  = r_out;
    assign io_bus.out_sat   = r_sat;
endmodule

// File: tb/tb_nn_mlp_seq.sv
// Bench for nn_mlp_seq: two instances (clip and ReLU activation) driven in lockstep and
// compared against an integer model of the network evaluated on the bench's weight copy.
module tb_nn_mlp_seq;
    localparam int N_IN  = 7;
    localparam int N_HID = 13;
    localparam int W     = 17;
    localparam int F     = 12;
    localparam int ACC_W = 40;
    localparam int B     = N_HID * (N_IN + 1);
    localparam int NW    = B + N_HID + 1;
    localparam int AW    = $clog2(NW);
    localparam int L     = N_HID * (N_IN + 2) + N_HID + 2;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));
    localparam longint ONE  = longint'(1) << F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              w_we = 1'b0;
    logic [N_IN*W-1:0] in_data = '0;
    logic [AW-1:0]     w_addr = '0;
    logic [W-1:0]      w_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    int mw [NW];
    int xs [N_IN];
    int obs_lat;
    logic [W-1:0] obs_d [2];
    logic obs_s [2], obs_rdy [2], obs_vld [2], obs_busy [2];
    int exp_d [2];
    bit exp_s [2];

    nn_mlp_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .W(W)) bus0 ();
    nn_mlp_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .W(W)) bus1 ();

    assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
    assign bus0.in_data = in_data;     assign bus1.in_data = in_data;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
    assign bus0.w_we = w_we;           assign bus1.w_we = w_we;
    assign bus0.w_addr = w_addr;       assign bus1.w_addr = w_addr;
    assign bus0.w_data = w_data;       assign bus1.w_data = w_data;

    nn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .W(W), .F(F), .ACC_W(ACC_W), .ACT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io_bus(bus0)
    );
    nn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .W(W), .F(F), .ACC_W(ACC_W), .ACT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .io_bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic longint clamp_w(input longint v, inout bit s);
        if (v > SMAX) begin s = 1'b1; return SMAX; end
        if (v < SMIN) begin s = 1'b1; return SMIN; end
        return v;
    endfunction

    // Network evaluated directly from the weight map on the bench's copy of the weights.
    function automatic void model(input int act, output int y, output bit s);
        longint acc, hv;
        longint hid [N_HID];
        s = 1'b0;
        for (int h = 0; h < N_HID; h++) begin
            acc = longint'(mw[h * (N_IN + 1) + N_IN]) * ONE;
            for (int i = 0; i < N_IN; i++) acc += longint'(xs[i]) * longint'(mw[h * (N_IN + 1) + i]);
            hv = clamp_w(acc >>> F, s);
            if (act == 0) begin
                if (hv > ONE)  hv = ONE;
                if (hv < -ONE) hv = -ONE;
            end else if (hv < 0) begin
                hv = 0;
            end
            hid[h] = hv;
        end
        acc = longint'(mw[B + N_HID]) * ONE;
        for (int j = 0; j < N_HID; j++) acc += hid[j] * longint'(mw[B + j]);
        y = int'(clamp_w(acc >>> F, s));
    endfunction

    task automatic predict();
        model(0, exp_d[0], exp_s[0]);
        model(1, exp_d[1], exp_s[1]);
    endtask

    task automatic sample();
        obs_d[0] = bus0.out_data;    obs_d[1] = bus1.out_data;
        obs_s[0] = bus0.out_sat;     obs_s[1] = bus1.out_sat;
        obs_rdy[0] = bus0.in_ready;  obs_rdy[1] = bus1.in_ready;
        obs_vld[0] = bus0.out_valid; obs_vld[1] = bus1.out_valid;
        obs_busy[0] = bus0.busy;     obs_busy[1] = bus1.busy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; w_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) mw[i] = 0;
    endtask

    task automatic write_w(input int a, input int v, input bit upd);
        @(negedge clk);
        w_we = 1'b1; w_addr = AW'(a); w_data = W'(v);
        @(negedge clk);
        w_we = 1'b0;
        if (upd) mw[a] = v;
    endtask

    task automatic rand_x(input int lim);
        for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 2 * lim)) - lim;
    endtask

    task automatic launch();
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) in_data[(N_IN - 1 - i) * W +: W] = W'(xs[i]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Accept a vector and count edges until out_valid; -1 marks an expired bound.
    task automatic start_wait();
        launch();
        obs_lat = -1;
        for (int c = 1; c <= L + 50; c++) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid) begin obs_lat = c; break; end
        end
        sample();
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sample();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_rdy[k] !== 1'b1 || obs_vld[k] !== 1'b0 || obs_busy[k] !== 1'b0 ||
                obs_d[k] !== '0 || obs_s[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b busy=%b data=%h sat=%b, want 1 0 0 0 0",
                         k, obs_rdy[k], obs_vld[k], obs_busy[k], obs_d[k], obs_s[k]);
            end
        end
    endtask

    task automatic test_bias_only();
        do_reset();
        write_w(B + N_HID, 'h800, 1'b1);
        rand_x(60000);
        start_wait();
        n_checks++;
        if (obs_lat != L) begin
            n_errors++; $display("FAIL bias_latency got %0d want %0d", obs_lat, L);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_d[k] !== 17'h00800 || obs_s[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL bias_out dut%0d got %h/%b want 00800/0", k, obs_d[k], obs_s[k]);
            end
        end
        handshake();
        sample();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_rdy[k] !== 1'b1 || obs_vld[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL post_handshake dut%0d rdy=%b vld=%b want 1 0", k, obs_rdy[k], obs_vld[k]);
            end
        end
    endtask

    task automatic test_identity();
        int x1 [3];
        int want [3][2];
        x1 = '{'h400, 'h3000, -4096};
        want = '{'{'h400, 'h400}, '{'h1000, 'h3000}, '{'h1F000, 0}};
        do_reset();
        write_w(0, 'h1000, 1'b1);
        write_w(B, 'h1000, 1'b1);
        for (int t = 0; t < 3; t++) begin
            rand_x(30000);
            xs[0] = x1[t];
            start_wait();
            n_checks++;
            if (obs_lat != L) begin
                n_errors++; $display("FAIL identity_latency case %0d got %0d want %0d", t, obs_lat, L);
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_d[k] !== W'(want[t][k]) || obs_s[k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL identity case %0d dut%0d got %h/%b want %h/0",
                             t, k, obs_d[k], obs_s[k], W'(want[t][k]));
                end
            end
            handshake();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int a = 0; a < NW; a++) write_w(a, int'($urandom_range(0, 16384)) - 8192, 1'b1);
        for (int t = 0; t < 4; t++) begin
            rand_x(16384);
            predict();
            start_wait();
            n_checks++;
            if (obs_lat != L) begin
                n_errors++; $display("FAIL random_latency run %0d got %0d want %0d", t, obs_lat, L);
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_d[k] !== W'(exp_d[k]) || obs_s[k] !== exp_s[k]) begin
                    n_errors++;
                    $display("FAIL random run %0d dut%0d got %h/%b want %h/%b",
                             t, k, obs_d[k], obs_s[k], W'(exp_d[k]), exp_s[k]);
                end
            end
            handshake();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int h = 0; h < N_HID; h++) write_w(h * (N_IN + 1) + N_IN, 'h1000, 1'b1);
        for (int j = 0; j <= N_HID; j++) write_w(B + j, 'hFFFF, 1'b1);
        for (int t = 0; t < 2; t++) begin
            // Second pass: a single full-scale output weight lands exactly on the positive limit.
            if (t == 1) begin
                write_w(B + N_HID, 0, 1'b1);
                for (int j = 1; j < N_HID; j++) write_w(B + j, 0, 1'b1);
            end
            rand_x(30000);
            predict();
            start_wait();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_d[k] !== W'(exp_d[k]) || obs_s[k] !== exp_s[k] ||
                    obs_d[k] !== 17'h0FFFF || obs_s[k] !== (t == 0)) begin
                    n_errors++;
                    $display("FAIL saturation pass %0d dut%0d got %h/%b want %h/%b",
                             t, k, obs_d[k], obs_s[k], W'(exp_d[k]), exp_s[k]);
                end
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held [2];
        rand_x(30000);
        predict();
        start_wait();
        held = obs_d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            w_we = (c == 5); w_addr = AW'(B); w_data = '0;
            in_valid = (c >= 8 && c < 12);
            in_data = ~in_data;
            sample();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vld[k] !== 1'b1 || obs_rdy[k] !== 1'b0 || obs_d[k] !== held[k] ||
                    obs_d[k] !== W'(exp_d[k])) begin
                    n_errors++;
                    $display("FAIL backpressure cyc %0d dut%0d vld=%b rdy=%b data=%h want 1 0 %h",
                             c, k, obs_vld[k], obs_rdy[k], obs_d[k], W'(exp_d[k]));
                end
            end
        end
        @(negedge clk);
        w_we = 1'b0; in_valid = 1'b0;
        handshake();
        sample();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_busy[k] !== 1'b0 || obs_rdy[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL busy_ignore dut%0d busy=%b rdy=%b want 0 1", k, obs_busy[k], obs_rdy[k]);
            end
        end
        // The write during busy must not have changed the output weight.
        start_wait();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_d[k] !== W'(exp_d[k]) || obs_s[k] !== exp_s[k]) begin
                n_errors++;
                $display("FAIL busy_write_rerun dut%0d got %h/%b want %h/%b",
                         k, obs_d[k], obs_s[k], W'(exp_d[k]), exp_s[k]);
            end
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        do_reset();
        write_w(0, 'h1000, 1'b1);
        write_w(B, 'h1000, 1'b1);
        rand_x(30000);
        xs[0] = 'h400;
        launch();
        repeat (49) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 sample();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vld[k] !== 1'b0 || obs_rdy[k] !== 1'b1 || obs_busy[k] !== 1'b0 ||
                obs_d[k] !== '0) begin
                n_errors++;
                $display("FAIL abort dut%0d vld=%b rdy=%b busy=%b data=%h want 0 1 0 0",
                         k, obs_vld[k], obs_rdy[k], obs_busy[k], obs_d[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) mw[i] = 0;
        for (int t = 0; t < 2; t++) begin
            if (t == 1) begin
                write_w(0, 'h1000, 1'b1);
                write_w(B, 'h1000, 1'b1);
            end
            predict();
            start_wait();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_d[k] !== W'(exp_d[k]) || obs_s[k] !== exp_s[k]) begin
                    n_errors++;
                    $display("FAIL after_abort pass %0d dut%0d got %h/%b want %h/%b",
                             t, k, obs_d[k], obs_s[k], W'(exp_d[k]), exp_s[k]);
                end
            end
            handshake();
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mw[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_bias_only();
        test_identity();
        test_random();
        test_saturation();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
